// File: rtl/regbank_arbiter.sv
// Round-robin two-port arbiter and clear sequencer in front of registers_bank.
// Owns the bank's write port and A/B read addresses and returns registered read data.
module regbank_arbiter #(
    parameter int size_reg = 16,
    parameter int addr_reg = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_req,
    output logic                busy,

    input  logic                req0,
    input  logic                we0,
    input  logic [addr_reg-1:0] addr_a0,
    input  logic [addr_reg-1:0] addr_b0,
    input  logic [addr_reg-1:0] addr_r0,
    input  logic [size_reg-1:0] wdata0,
    output logic                gnt0,
    output logic                rvalid0,
    output logic [size_reg-1:0] rdata_a0,
    output logic [size_reg-1:0] rdata_b0,

    input  logic                req1,
    input  logic                we1,
    input  logic [addr_reg-1:0] addr_a1,
    input  logic [addr_reg-1:0] addr_b1,
    input  logic [addr_reg-1:0] addr_r1,
    input  logic [size_reg-1:0] wdata1,
    output logic                gnt1,
    output logic                rvalid1,
    output logic [size_reg-1:0] rdata_a1,
    output logic [size_reg-1:0] rdata_b1,

    output logic [addr_reg-1:0] bank_addr_A,
    output logic [addr_reg-1:0] bank_addr_B,
    output logic [addr_reg-1:0] bank_addr_R,
    output logic                bank_write_reg,
    output logic                bank_read_reg,
    output logic [size_reg-1:0] bank_write_data,
    input  logic [size_reg-1:0] bank_data_A,
    input  logic [size_reg-1:0] bank_data_B
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [addr_reg-1:0] LastAddr = '1;

    state_t              state, state_next;
    logic [addr_reg-1:0] counter, counter_next;
    logic                pointer, pointer_next;

    // Read data is sampled from the bank at the grant edge, so a same-register
    // write in that transaction is not yet visible to it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            counter  <= '0;
            pointer  <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata_a0 <= '0;
            rdata_b0 <= '0;
            rdata_a1 <= '0;
            rdata_b1 <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            pointer <= pointer_next;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0) begin
                rdata_a0 <= bank_data_A;
                rdata_b0 <= bank_data_B;
            end
            if (gnt1) begin
                rdata_a1 <= bank_data_A;
                rdata_b1 <= bank_data_B;
            end
        end
    end

    always_comb begin
        state_next      = state;
        counter_next    = counter;
        pointer_next    = pointer;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        busy            = 1'b0;
        bank_addr_A     = '0;
        bank_addr_B     = '0;
        bank_addr_R     = '0;
        bank_write_reg  = 1'b0;
        bank_read_reg   = 1'b0;
        bank_write_data = '0;

        case (state)
            CLEAR: begin
                busy           = 1'b1;
                bank_write_reg = 1'b1;
                bank_addr_R    = counter;
                counter_next   = counter + 1'b1;
                if (counter == LastAddr) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The counter has already wrapped to 0, so a new clear starts at register 0.
                if (clear_req) begin
                    state_next = CLEAR;
                end else if (req0 && req1) begin
                    gnt0         = !pointer;
                    gnt1         = pointer;
                    pointer_next = !pointer;
                end else if (req0) begin
                    gnt0         = 1'b1;
                    pointer_next = 1'b1;
                end else if (req1) begin
                    gnt1         = 1'b1;
                    pointer_next = 1'b0;
                end
            end
            default: state_next = CLEAR;
        endcase

        if (gnt0) begin
            bank_read_reg   = 1'b1;
            bank_write_reg  = we0;
            bank_addr_A     = addr_a0;
            bank_addr_B     = addr_b0;
            bank_addr_R     = addr_r0;
            bank_write_data = wdata0;
        end else if (gnt1) begin
            bank_read_reg   = 1'b1;
            bank_write_reg  = we1;
            bank_addr_A     = addr_a1;
            bank_addr_B     = addr_b1;
            bank_addr_R     = addr_r1;
            bank_write_data = wdata1;
        end
    end

endmodule
